// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the instruction-fetch next-PC stage.
package fetch_pc_gen_pkg;

    localparam int INSTR_BYTES = 4;

    // Widest possible BTB tag (pc[31:2] with a zero-bit index); narrower
    // tags are zero-extended into this field.
    localparam int BTB_TAG_W_MAX = 30;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        REFILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_W_MAX-1:0] tag;
        logic [31:0]              target;
    } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: one combinational lookup port and
// one write port. Only the valid bits are reset; tags and targets are not.
// A write and a lookup on the same index in one cycle return the old entry.
module fetch_btb
    import fetch_pc_gen_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] rd_pc_i,
    output logic        rd_hit_o,
    output logic [31:0] rd_target_o,
    input  logic        wr_en_i,
    input  logic [31:2] wr_pc_i,
    input  logic [31:0] wr_target_i
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic [TAG_W-1:0]    wr_tag;
    btb_entry_t          rd_entry;

    assign rd_idx = rd_pc_i[IDX_BITS+1:2];
    assign rd_tag = rd_pc_i[31:IDX_BITS+2];
    assign wr_idx = wr_pc_i[IDX_BITS+1:2];
    assign wr_tag = wr_pc_i[31:IDX_BITS+2];

    // Assemble the indexed entry and compare tags for a hit.
    always_comb begin
        rd_entry.valid  = valid_q[rd_idx];
        rd_entry.tag    = {{IDX_BITS{1'b0}}, tag_q[rd_idx]};
        rd_entry.target = target_q[rd_idx];
        rd_hit_o        = rd_entry.valid && (rd_entry.tag == {{IDX_BITS{1'b0}}, rd_tag});
        rd_target_o     = rd_entry.target;
    end

    // Next valid vector: a write marks its entry valid.
    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Valid bits, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target storage, written without reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target_i;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch next-PC stage: fetch PC register, BTB, next-PC select
// and EX mispredict redirect.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating performance
// counters (branches, mispredicts, BTB hits on valid fetches).
//
// state  | meaning
// BOOT   | first cycle after reset release, PC held, fetch not valid
// RUN    | normal fetch
// REFILL | cycle after a redirect, fetch not valid
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          BTB_IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    input  logic        prediction_i,
    output logic [31:0] if_pc_o,
    output logic        if_valid_o,
    output logic        if_pred_taken_o,
    output logic [31:0] if_pred_target_o,
    input  logic        ex_resolve_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches_o,
    output logic [31:0] perf_mispredicts_o,
    output logic [31:0] perf_btb_hits_o
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] STEP             = 32'(INSTR_BYTES);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    logic        btb_hit;
    logic [31:0] btb_target;
    logic        mispredict;
    logic        hold;

    fetch_btb #(
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_pc_i     (pc_q[31:2]),
        .rd_hit_o    (btb_hit),
        .rd_target_o (btb_target),
        .wr_en_i     (ex_resolve_i && ex_taken_i),
        .wr_pc_i     (ex_pc_i[31:2]),
        .wr_target_i (ex_target_i)
    );

    // Prediction, mispredict detection and fetch-valid outputs.
    always_comb begin
        if_pc_o          = pc_q;
        if_pred_taken_o  = btb_hit && prediction_i;
        if_pred_target_o = if_pred_taken_o ? btb_target : pc_q + STEP;
        mispredict       = ex_resolve_i &&
                           ((ex_taken_i != ex_pred_taken_i) ||
                            (ex_taken_i && (ex_target_i != ex_pred_target_i)));
        // Redirect is forced low while reset is asserted.
        redirect_o       = mispredict && rst_n;
        redirect_pc_o    = ex_taken_i ? ex_target_i : ex_pc_i + STEP;
        hold             = stall_i || !imem_ready_i || (state_q == BOOT);
        if_valid_o       = (state_q == RUN) && imem_ready_i && !stall_i && !redirect_o;
    end

    // Next-PC select and FSM next state; redirect beats stall.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_o) begin
            pc_d = {redirect_pc_o[31:2], 2'b00};
        end else if (hold) begin
            pc_d = pc_q;
        end else begin
            pc_d = {if_pred_target_o[31:2], 2'b00};
        end
        if (redirect_o) begin
            state_d = REFILL;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = RUN;
                REFILL:  state_d = RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    // PC and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC_ALIGNED;
            state_q <= BOOT;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_mp_q, perf_mp_d;
    logic [31:0] perf_hit_q, perf_hit_d;

    // Saturating event counters.
    always_comb begin
        perf_br_d  = perf_br_q;
        perf_mp_d  = perf_mp_q;
        perf_hit_d = perf_hit_q;
        if (ex_resolve_i && (perf_br_q != 32'hFFFF_FFFF)) begin
            perf_br_d = perf_br_q + 32'd1;
        end
        if (redirect_o && (perf_mp_q != 32'hFFFF_FFFF)) begin
            perf_mp_d = perf_mp_q + 32'd1;
        end
        if (btb_hit && if_valid_o && (perf_hit_q != 32'hFFFF_FFFF)) begin
            perf_hit_d = perf_hit_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q  <= '0;
            perf_mp_q  <= '0;
            perf_hit_q <= '0;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mp_q  <= perf_mp_d;
            perf_hit_q <= perf_hit_d;
        end
    end

    assign perf_branches_o    = perf_br_q;
    assign perf_mispredicts_o = perf_mp_q;
    assign perf_btb_hits_o    = perf_hit_q;
`endif

endmodule
